// File: rtl/feedback_suppressor_pkg.sv
// ============================================================================
// Module      : feedback_suppressor_pkg
// Description : Shared gain-path types and constants for the howl suppressor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package feedback_suppressor_pkg;

  localparam int UNITY_GAIN = 256;
  localparam int GAIN_W     = 9;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    SUPPRESS = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  function automatic int saturate(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fs_howl_detector.sv
// ============================================================================
// Module      : fs_howl_detector
// Description : Envelope follower plus zero-crossing period tracker; flags a
//               sustained, stable-period, high-level tone.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_howl_detector #(
  parameter int DATA_W       = 8,
  parameter int ENV_SHIFT    = 4,
  parameter int LEVEL_THRESH = 32,
  parameter int MIN_PERIOD   = 4,
  parameter int MAX_PERIOD   = 255,
  parameter int PERIOD_TOL   = 1,
  parameter int STABLE_COUNT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_howl,
  output logic              o_zc_stable
);

  localparam int c_ACC_W  = DATA_W + ENV_SHIFT;
  localparam int c_PER_W  = $clog2(MAX_PERIOD + 1);
  localparam int c_STAB_W = $clog2(STABLE_COUNT + 1);

  logic [c_ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]   r_prev;
  logic [c_PER_W-1:0]  r_cnt;
  logic [c_PER_W-1:0]  r_pprev;
  logic [c_STAB_W-1:0] r_stab;

  logic [DATA_W:0]     w_sext;
  logic [DATA_W:0]     w_mag;
  logic [DATA_W-1:0]   w_env;
  logic [c_PER_W-1:0]  w_diff;
  logic                w_zc;
  logic                w_cnt_sat;
  logic                w_stable;

  // One extra bit so that |-2^(DATA_W-1)| is representable.
  assign w_sext    = {i_data[DATA_W-1], i_data};
  assign w_mag     = i_data[DATA_W-1] ? (~w_sext + {{DATA_W{1'b0}}, 1'b1}) : w_sext;
  assign w_env     = r_acc[c_ACC_W-1:ENV_SHIFT];

  assign w_zc      = r_prev[DATA_W-1] & ~i_data[DATA_W-1];
  assign w_cnt_sat = (r_cnt == c_PER_W'(MAX_PERIOD));
  assign w_diff    = (r_cnt >= r_pprev) ? (r_cnt - r_pprev) : (r_pprev - r_cnt);
  assign w_stable  = (r_cnt >= c_PER_W'(MIN_PERIOD)) && (r_cnt < c_PER_W'(MAX_PERIOD)) &&
                     (w_diff <= c_PER_W'(PERIOD_TOL));

  assign o_zc_stable = w_zc & w_stable;
  assign o_howl      = (r_stab == c_STAB_W'(STABLE_COUNT)) && (w_env >= DATA_W'(LEVEL_THRESH));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc   <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_pprev <= '0;
      r_stab  <= '0;
    end else begin
      r_acc  <= r_acc + c_ACC_W'(w_mag) - (r_acc >> ENV_SHIFT);
      r_prev <= i_data;
      if (w_zc) begin
        r_pprev <= r_cnt;
        r_cnt   <= c_PER_W'(1);
        if (w_stable) begin
          if (r_stab != c_STAB_W'(STABLE_COUNT)) r_stab <= r_stab + c_STAB_W'(1);
        end else begin
          r_stab <= '0;
        end
      end else if (w_cnt_sat) begin
        r_stab <= '0;
      end else begin
        r_cnt <= r_cnt + c_PER_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/feedback_suppressor.sv
// ============================================================================
// Module      : feedback_suppressor
// Description : Acoustic-feedback suppressor; gain FSM and output multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feedback_suppressor
  import feedback_suppressor_pkg::*;
#(
  parameter int DATA_W           = 8,
  parameter int ENV_SHIFT        = 4,
  parameter int LEVEL_THRESH     = 32,
  parameter int MIN_PERIOD       = 4,
  parameter int MAX_PERIOD       = 255,
  parameter int PERIOD_TOL       = 1,
  parameter int STABLE_COUNT     = 8,
  parameter int ATTACK_STEP      = 16,
  parameter int MIN_GAIN         = 32,
  parameter int RELEASE_STEP     = 1,
  parameter int RELEASE_INTERVAL = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int c_TIMER_W = $clog2(RELEASE_INTERVAL);
  localparam int c_OUT_MIN = -(2 ** (DATA_W - 1));
  localparam int c_OUT_MAX = (2 ** (DATA_W - 1)) - 1;

  logic w_howl;
  logic w_zc_stable;

  fs_howl_detector #(
    .DATA_W       (DATA_W),
    .ENV_SHIFT    (ENV_SHIFT),
    .LEVEL_THRESH (LEVEL_THRESH),
    .MIN_PERIOD   (MIN_PERIOD),
    .MAX_PERIOD   (MAX_PERIOD),
    .PERIOD_TOL   (PERIOD_TOL),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_detector (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_data      (i_data),
    .o_howl      (w_howl),
    .o_zc_stable (w_zc_stable)
  );

  state_t                 r_state, w_state_nxt;
  logic [GAIN_W-1:0]      r_gain, w_gain_nxt;
  logic [c_TIMER_W-1:0]   r_timer, w_timer_nxt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= PASS;
      r_gain  <= GAIN_W'(UNITY_GAIN);
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_timer_nxt = r_timer;
    case (r_state)
      PASS: begin
        w_gain_nxt = GAIN_W'(UNITY_GAIN);
        if (w_howl) w_state_nxt = SUPPRESS;
      end
      SUPPRESS: begin
        if (!w_howl) begin
          w_state_nxt = RELEASE;
          w_timer_nxt = '0;
        end else if (w_zc_stable) begin
          if (r_gain >= GAIN_W'(MIN_GAIN + ATTACK_STEP))
            w_gain_nxt = r_gain - GAIN_W'(ATTACK_STEP);
          else
            w_gain_nxt = GAIN_W'(MIN_GAIN);
        end
      end
      RELEASE: begin
        // A re-detected howl pre-empts a release tick landing on the same clock.
        if (w_howl) begin
          w_state_nxt = SUPPRESS;
          w_timer_nxt = '0;
        end else if (r_timer == c_TIMER_W'(RELEASE_INTERVAL - 1)) begin
          w_timer_nxt = '0;
          if (r_gain >= GAIN_W'(UNITY_GAIN - RELEASE_STEP)) begin
            w_gain_nxt  = GAIN_W'(UNITY_GAIN);
            w_state_nxt = PASS;
          end else begin
            w_gain_nxt = r_gain + GAIN_W'(RELEASE_STEP);
          end
        end else begin
          w_timer_nxt = r_timer + c_TIMER_W'(1);
        end
      end
      default: begin
        w_state_nxt = PASS;
        w_gain_nxt  = GAIN_W'(UNITY_GAIN);
      end
    endcase
  end

  logic signed [DATA_W+9:0] w_prod;
  logic signed [DATA_W+9:0] w_shift;
  int                       w_sat;

  assign w_prod  = $signed(i_data) * $signed({1'b0, r_gain});
  assign w_shift = w_prod >>> 8;
  assign w_sat   = saturate(int'(w_shift), c_OUT_MIN, c_OUT_MAX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_data <= '0;
    else         o_data <= DATA_W'(w_sat);
  end

endmodule

`default_nettype wire

// File: tb/tb_feedback_suppressor.sv
// ============================================================================
// Module      : tb_feedback_suppressor
// Description : Randomized bench with a behavioural model of the suppressor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_feedback_suppressor;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic [7:0] o_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  feedback_suppressor dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .o_data  (o_data)
  );

  // Behavioural model: 0=pass, 1=suppress, 2=release
  int m_prev, m_cnt, m_pprev, m_stab, m_acc, m_gain, m_mode, m_rel;

  function automatic int model_step(input int x, input bit rst);
    int e, ax, dp;
    bit zc, stz, howl;
    if (rst) begin
      m_prev = 0; m_cnt = 0; m_pprev = 0; m_stab = 0; m_acc = 0;
      m_gain = 256; m_mode = 0; m_rel = 0;
      return 0;
    end
    e = (x * m_gain) >>> 8;
    if (e > 127) e = 127;
    if (e < -128) e = -128;
    howl = (m_stab == 8) && ((m_acc / 16) >= 32);
    zc   = (m_prev < 0) && (x >= 0);
    dp   = (m_cnt > m_pprev) ? m_cnt - m_pprev : m_pprev - m_cnt;
    stz  = zc && (m_cnt >= 4) && (m_cnt < 255) && (dp <= 1);
    if (m_mode == 0) begin
      m_gain = 256;
      if (howl) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!howl) begin m_mode = 2; m_rel = 0; end
      else if (stz) m_gain = (m_gain - 16 < 32) ? 32 : m_gain - 16;
    end else begin
      if (howl) begin m_mode = 1; m_rel = 0; end
      else begin
        m_rel++;
        if (m_rel % 64 == 0) begin
          m_gain = m_gain + 1;
          if (m_gain >= 256) begin m_gain = 256; m_mode = 0; end
        end
      end
    end
    ax = (x < 0) ? -x : x;
    m_acc = m_acc + ax - (m_acc / 16);
    if (zc) begin
      m_stab  = stz ? ((m_stab < 8) ? m_stab + 1 : 8) : 0;
      m_pprev = m_cnt;
      m_cnt   = 1;
    end else begin
      if (m_cnt == 255) m_stab = 0;
      else m_cnt = m_cnt + 1;
    end
    m_prev = x;
    return e;
  endfunction

  int c_x, c_exp;
  bit c_rst;
  always begin
    @(posedge clk);
    c_x   = int'($signed(i_data));
    c_rst = i_reset;
    c_exp = model_step(c_x, c_rst);
    #1;
    checks++;
    if (o_data !== 8'(c_exp)) begin
      failures++;
      $display("FAIL model_cmp t=%0t got=%0d exp=%0d", $time, $signed(o_data), c_exp);
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic send(input int x);
    @(negedge clk);
    i_data = 8'(x);
    @(posedge clk);
    #2;
  endtask

  function automatic int out_s();
    return int'($signed(o_data));
  endfunction

  int gq[$];
  int x, n;

  initial begin
    i_reset = 1'b1;
    i_data  = 8'h55;
    repeat (5) begin
      @(posedge clk); #2;
      check("reset_out", out_s(), 0);
    end
    check("reset_gain", m_gain, 256);
    @(negedge clk) i_reset = 1'b0;
    send(8'h40); check("post_reset_40", out_s(), 64);

    // unity pass
    repeat (10) begin
      x = int'($urandom_range(255)) - 128;
      send(x); check("unity_rand", out_s(), x);
    end
    send(-128); check("unity_80", out_s(), -128);
    send(127);  check("unity_7f", out_s(), 127);

    // howl: +/-100, period 16, 40 periods
    gq.push_back(m_gain);
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 16; i++) begin
        send(i < 8 ? 100 : -100);
        if (m_gain != gq[gq.size()-1]) gq.push_back(m_gain);
      end
    end
    check("howl_gain0", gq[0], 256);
    check("howl_gain1", (gq.size() > 1) ? gq[1] : -1, 240);
    check("howl_floor", m_gain, 32);
    check("howl_neg_out", out_s(), -13);

    // release
    repeat (64 * 224 + 300) send(0);
    check("release_gain", m_gain, 256);
    check("release_mode", m_mode, 0);
    send(8'h40); check("release_40", out_s(), 64);

    // low-level tone must not trigger
    for (int p = 0; p < 20; p++)
      for (int i = 0; i < 16; i++) send(i < 8 ? 20 : -20);
    check("lowtone_gain", m_gain, 256);
    check("lowtone_out", out_s(), -20);
    repeat (300) send(0);

    // random noise must not trigger
    repeat (300) send(int'($urandom_range(255)) - 128);
    check("noise_gain", m_gain, 256);

    // reach gain 128 then hit async reset mid-suppress
    n = 0;
    while (m_gain != 128 && n < 4000) begin
      send((n % 16) < 8 ? 100 : -100);
      n++;
    end
    check("reach_g128", m_gain, 128);
    check("reach_mode", m_mode, 1);
    @(negedge clk); #1;
    i_reset = 1'b1;
    #1;
    check("async_reset_out", out_s(), 0);
    @(posedge clk); #2;
    check("async_reset_hold", out_s(), 0);
    @(negedge clk) i_reset = 1'b0;
    send(8'h40); check("after_reset_40", out_s(), 64);
    check("after_reset_gain", m_gain, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
